// File: rtl/dual_port_bram_pkg.sv
// Shared types and byte-lane helpers for dual_port_bram.
// Parity helpers are only referenced when DUAL_PORT_BRAM_PARITY_EN is defined.
package dual_port_bram_pkg;

  typedef logic [0:0] state_t;
  localparam state_t CLEAR = 1'b0;
  localparam state_t READY = 1'b1;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       en);
    return en ? new_byte : old_byte;
  endfunction

  // Even parity: stored bit makes the 9-bit group have an even number of ones.
  function automatic logic parity_byte(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dual_port_bram_outreg.sv
// Optional one-stage output register for one read port (data + valid).
module dual_port_bram_outreg
  import dual_port_bram_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int OUTPUT_REG = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             validIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             validOut
);

  if (OUTPUT_REG != 0) begin : g_reg
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        dataOut  <= '0;
        validOut <= 1'b0;
      end else begin
        validOut <= validIn;
        if (validIn) dataOut <= dataIn;
      end
    end
  end else begin : g_bypass
    logic unused_clk;
    assign unused_clk = clock ^ reset;
    assign dataOut    = dataIn;
    assign validOut   = validIn;
  end

endmodule

// File: rtl/dual_port_bram.sv
// True dual-port byte-writable RAM with self-clearing start-up sequence.
// Define DUAL_PORT_BRAM_PARITY_EN to add per-byte even parity and parityErrorA/B.
module dual_port_bram
  import dual_port_bram_pkg::*;
#(
  parameter int BITWIDTH         = 32,
  parameter int NR_OF_ENTRIES    = 512,
  parameter int READ_AFTER_WRITE = 0,
  parameter int OUTPUT_REG       = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             clearRequest,
  output logic                             ready,
  input  logic                             enableA,
  input  logic                             enableB,
  input  logic                             writeEnableA,
  input  logic                             writeEnableB,
  input  logic [BITWIDTH/8-1:0]            byteEnableA,
  input  logic [BITWIDTH/8-1:0]            byteEnableB,
  input  logic [$clog2(NR_OF_ENTRIES)-1:0] addressA,
  input  logic [$clog2(NR_OF_ENTRIES)-1:0] addressB,
  input  logic [BITWIDTH-1:0]              dataInA,
  input  logic [BITWIDTH-1:0]              dataInB,
  output logic [BITWIDTH-1:0]              dataOutA,
  output logic [BITWIDTH-1:0]              dataOutB,
  output logic                             validOutA,
  output logic                             validOutB,
  output logic                             collision
`ifdef DUAL_PORT_BRAM_PARITY_EN
  ,
  output logic                             parityErrorA,
  output logic                             parityErrorB
`endif
);

  localparam int unsigned NB = BITWIDTH / 8;
  localparam int          AW = $clog2(NR_OF_ENTRIES);
`ifdef DUAL_PORT_BRAM_PARITY_EN
  localparam int          OW = BITWIDTH + 1;
`else
  localparam int          OW = BITWIDTH;
`endif

  function automatic logic [BITWIDTH-1:0] merge_word(input logic [BITWIDTH-1:0] old_w,
                                                     input logic [BITWIDTH-1:0] new_w,
                                                     input logic [NB-1:0]       be);
    logic [BITWIDTH-1:0] r;
    for (int unsigned i = 0; i < NB; i++)
      r[i*8 +: 8] = merge_byte(old_w[i*8 +: 8], new_w[i*8 +: 8], be[i]);
    return r;
  endfunction

  state_t              state;
  logic [AW-1:0]       cnt;
  logic [BITWIDTH-1:0] mem [NR_OF_ENTRIES];

  logic                acc, inA, inB, wrA, wrB, rdA, rdB, sameAddr;
  logic [BITWIDTH-1:0] oldA, oldB, nwA, nwB, rdataA, rdataB;
  logic [OW-1:0]       rbA, rbB, s1A, s1B, oA, oB;
  logic                s1ValidA, s1ValidB;

  assign ready    = (state == READY);
  assign acc      = (state == READY);
  assign inA      = 32'(addressA) < NR_OF_ENTRIES;
  assign inB      = 32'(addressB) < NR_OF_ENTRIES;
  assign wrA      = acc && enableA && writeEnableA && inA;
  assign wrB      = acc && enableB && writeEnableB && inB;
  assign rdA      = acc && enableA && !writeEnableA;
  assign rdB      = acc && enableB && !writeEnableB;
  assign sameAddr = (addressA == addressB);

  // B is merged first and A on top, so A owns every byte it enables on a shared address.
  always_comb begin
    oldA = inA ? mem[addressA] : '0;
    oldB = inB ? mem[addressB] : '0;
    nwA  = oldA;
    if (wrB && sameAddr) nwA = merge_word(nwA, dataInB, byteEnableB);
    if (wrA)             nwA = merge_word(nwA, dataInA, byteEnableA);
    nwB  = oldB;
    if (wrB)             nwB = merge_word(nwB, dataInB, byteEnableB);
    if (wrA && sameAddr) nwB = merge_word(nwB, dataInA, byteEnableA);
    rdataA = !inA ? '0 : (READ_AFTER_WRITE != 0) ? nwA : oldA;
    rdataB = !inB ? '0 : (READ_AFTER_WRITE != 0) ? nwB : oldB;
  end

`ifdef DUAL_PORT_BRAM_PARITY_EN
  function automatic logic [NB-1:0] parity_word(input logic [BITWIDTH-1:0] w);
    logic [NB-1:0] p;
    for (int unsigned i = 0; i < NB; i++) p[i] = parity_byte(w[i*8 +: 8]);
    return p;
  endfunction

  function automatic logic [NB-1:0] merge_par(input logic [NB-1:0]       old_p,
                                              input logic [BITWIDTH-1:0] new_w,
                                              input logic [NB-1:0]       be);
    logic [NB-1:0] p;
    p = parity_word(new_w);
    for (int unsigned i = 0; i < NB; i++) p[i] = be[i] ? p[i] : old_p[i];
    return p;
  endfunction

  logic [NB-1:0] par [NR_OF_ENTRIES];
  logic [NB-1:0] oldPA, oldPB, nwPA, nwPB;
  logic          errA, errB;

  always_comb begin
    oldPA = inA ? par[addressA] : '0;
    oldPB = inB ? par[addressB] : '0;
    nwPA  = oldPA;
    if (wrB && sameAddr) nwPA = merge_par(nwPA, dataInB, byteEnableB);
    if (wrA)             nwPA = merge_par(nwPA, dataInA, byteEnableA);
    nwPB  = oldPB;
    if (wrB)             nwPB = merge_par(nwPB, dataInB, byteEnableB);
    if (wrA && sameAddr) nwPB = merge_par(nwPB, dataInA, byteEnableA);
    errA = inA && ((READ_AFTER_WRITE != 0) ? |(nwPA ^ parity_word(nwA))
                                           : |(oldPA ^ parity_word(oldA)));
    errB = inB && ((READ_AFTER_WRITE != 0) ? |(nwPB ^ parity_word(nwB))
                                           : |(oldPB ^ parity_word(oldB)));
  end

  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      par[cnt] <= '0;
    end else begin
      if (wrA) par[addressA] <= nwPA;
      if (wrB) par[addressB] <= nwPB;
    end
  end

  assign rbA          = {errA, rdataA};
  assign rbB          = {errB, rdataB};
  assign parityErrorA = oA[BITWIDTH];
  assign parityErrorB = oB[BITWIDTH];
`else
  assign rbA = rdataA;
  assign rbB = rdataB;
`endif

  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else begin
      if (wrA) mem[addressA] <= nwA;
      if (wrB) mem[addressB] <= nwB;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      cnt       <= '0;
      s1A       <= '0;
      s1B       <= '0;
      s1ValidA  <= 1'b0;
      s1ValidB  <= 1'b0;
      collision <= 1'b0;
    end else begin
      if (clearRequest) begin
        state <= CLEAR;
        cnt   <= '0;
      end else if (state == CLEAR) begin
        if (cnt == AW'(NR_OF_ENTRIES - 1)) state <= READY;
        else                               cnt   <= cnt + AW'(1);
      end
      s1ValidA  <= rdA;
      s1ValidB  <= rdB;
      if (rdA) s1A <= rbA;
      if (rdB) s1B <= rbB;
      collision <= wrA && wrB && sameAddr;
    end
  end

  dual_port_bram_outreg #(.WIDTH(OW), .OUTPUT_REG(OUTPUT_REG)) u_outA (
    .clock(clock), .reset(reset), .dataIn(s1A), .validIn(s1ValidA),
    .dataOut(oA), .validOut(validOutA)
  );

  dual_port_bram_outreg #(.WIDTH(OW), .OUTPUT_REG(OUTPUT_REG)) u_outB (
    .clock(clock), .reset(reset), .dataIn(s1B), .validIn(s1ValidB),
    .dataOut(oB), .validOut(validOutB)
  );

  assign dataOutA = oA[BITWIDTH-1:0];
  assign dataOutB = oB[BITWIDTH-1:0];

endmodule

// File: tb/tb_dual_port_bram.sv
// Bench for dual_port_bram: directed vectors, multi-cycle sequences and a
// randomized run against a byte-lane reference model (DUAL_PORT_BRAM_PARITY_EN optional).
module tb_dual_port_bram;
  parameter int RAW  = 0;
  parameter int OREG = 1;
  localparam int N     = 12;
  localparam int L     = 1 + OREG;
  localparam int NV    = 14;
  localparam int NRAND = 2000;

  logic        clock, reset, clr, ready;
  logic        enA, enB, weA, weB;
  logic [3:0]  beA, beB, adA, adB;
  logic [31:0] dA, dB, dataOutA, dataOutB;
  logic        validOutA, validOutB, collision;
`ifdef DUAL_PORT_BRAM_PARITY_EN
  logic        parityErrorA, parityErrorB;
`endif

  dual_port_bram #(.BITWIDTH(32), .NR_OF_ENTRIES(N), .READ_AFTER_WRITE(RAW),
                   .OUTPUT_REG(OREG)) dut (
    .clock(clock), .reset(reset), .clearRequest(clr), .ready(ready),
    .enableA(enA), .enableB(enB), .writeEnableA(weA), .writeEnableB(weB),
    .byteEnableA(beA), .byteEnableB(beB), .addressA(adA), .addressB(adB),
    .dataInA(dA), .dataInB(dB), .dataOutA(dataOutA), .dataOutB(dataOutB),
    .validOutA(validOutA), .validOutB(validOutB), .collision(collision)
`ifdef DUAL_PORT_BRAM_PARITY_EN
    , .parityErrorA(parityErrorA), .parityErrorB(parityErrorB)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  typedef struct packed {
    logic        enA, weA; logic [3:0] beA, adA; logic [31:0] dA;
    logic        enB, weB; logic [3:0] beB, adB; logic [31:0] dB;
    logic        expC, expVA; logic [31:0] expDA; logic expVB; logic [31:0] expDB;
  } vec_t;

  typedef struct packed { logic v; logic [31:0] d; } exp_t;

  int          checks, errors;
  vec_t        vecs [NV];
  logic [31:0] m [N];
  int          clearLeft;
  exp_t        qA[$], qB[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    enA = 0; enB = 0; weA = 0; weB = 0; clr = 0;
    beA = '0; beB = '0; adA = '0; adB = '0; dA = '0; dB = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    idle(); enA = 1; weA = 1; adA = a; dA = d; beA = be;
    step(); idle();
  endtask

  task automatic rdA(input logic [3:0] a, input logic [31:0] exp, input string nm);
    idle(); enA = 1; adA = a;
    step(); idle();
    repeat (L - 1) step();
    check({nm, "_valid"}, validOutA, 1);
    check(nm, dataOutA, exp);
  endtask

  task automatic wait_ready(input int bound, output int n);
    n = 0;
    while (!ready && n < bound) begin step(); n++; end
  endtask

  task automatic read_all_zero(input string nm);
    for (int a = 0; a < N; a++) begin
      idle(); enA = 1; adA = 4'(a); enB = 1; adB = 4'(N - 1 - a);
      step(); idle();
      repeat (L - 1) step();
      check({nm, "_vA"}, validOutA, 1);
      check({nm, "_dA"}, dataOutA, 0);
      check({nm, "_vB"}, validOutB, 1);
      check({nm, "_dB"}, dataOutB, 0);
    end
  endtask

  function automatic vec_t mk(input logic ea, wa, input logic [3:0] ba, aa, input logic [31:0] da,
                              input logic eb, wb, input logic [3:0] bb, ab, input logic [31:0] db,
                              input logic c, va, input logic [31:0] xa,
                              input logic vb, input logic [31:0] xb);
    return '{ea, wa, ba, aa, da, eb, wb, bb, ab, db, c, va, xa, vb, xb};
  endfunction

  // Reference: each byte lane takes A's byte if A writes it, else B's, else the stored byte.
  function automatic logic [31:0] mnew(input int x, input logic wa, input logic wb);
    logic [31:0] r;
    r = m[x];
    for (int b = 0; b < 4; b++) begin
      if (wa && int'(adA) == x && beA[b])      r[b*8 +: 8] = dA[b*8 +: 8];
      else if (wb && int'(adB) == x && beB[b]) r[b*8 +: 8] = dB[b*8 +: 8];
    end
    return r;
  endfunction

  initial begin
    int          n;
    logic        acc, wa, wb, expC;
    logic [31:0] na, nb;
    exp_t        ea, eb, e;

    checks = 0; errors = 0;
    reset = 1; idle();

    vecs[0]  = mk(1,1,4'b0011,4'd5,32'hDEADBEEF, 0,0,4'b0000,4'd0,32'h0,        0, 0,32'h0,        0,32'h0);
    vecs[1]  = mk(1,0,4'b0000,4'd5,32'h0,        0,0,4'b0000,4'd0,32'h0,        0, 1,32'h0000BEEF, 0,32'h0);
    vecs[2]  = mk(1,1,4'b0011,4'd7,32'h11111111, 1,1,4'b1111,4'd7,32'h22222222, 1, 0,32'h0,        0,32'h0);
    vecs[3]  = mk(1,0,4'b0000,4'd7,32'h0,        1,0,4'b0000,4'd5,32'h0,        0, 1,32'h22221111, 1,32'h0000BEEF);
    vecs[4]  = mk(1,1,4'b1111,4'd3,32'hAAAAAAAA, 1,0,4'b0000,4'd3,32'h0,        0, 0,32'h0,
                  1, (RAW != 0) ? 32'hAAAAAAAA : 32'h0);
    vecs[5]  = mk(0,0,4'b0000,4'd0,32'h0,        1,0,4'b0000,4'd3,32'h0,        0, 0,32'h0,        1,32'hAAAAAAAA);
    vecs[6]  = mk(1,1,4'b0000,4'd5,32'h12345678, 1,1,4'b1111,4'd13,32'hFFFFFFFF,0, 0,32'h0,        0,32'h0);
    vecs[7]  = mk(1,0,4'b0000,4'd5,32'h0,        1,0,4'b0000,4'd13,32'h0,       0, 1,32'h0000BEEF, 1,32'h0);
    vecs[8]  = mk(0,0,4'b0000,4'd0,32'h0,        1,1,4'b1010,4'd11,32'h55AA55AA,0, 0,32'h0,        0,32'h0);
    vecs[9]  = mk(1,0,4'b0000,4'd11,32'h0,       1,0,4'b0000,4'd0,32'h0,        0, 1,32'h55005500, 1,32'h0);
    vecs[10] = mk(1,1,4'b1100,4'd2,32'hA1A2A3A4, 1,1,4'b0011,4'd2,32'hB1B2B3B4, 1, 0,32'h0,        0,32'h0);
    vecs[11] = mk(1,0,4'b0000,4'd2,32'h0,        1,0,4'b0000,4'd2,32'h0,        0, 1,32'hA1A2B3B4, 1,32'hA1A2B3B4);
    vecs[12] = mk(1,1,4'b1111,4'd4,32'h01234567, 1,1,4'b1111,4'd6,32'h89ABCDEF, 0, 0,32'h0,        0,32'h0);
    vecs[13] = mk(1,0,4'b0000,4'd6,32'h0,        1,0,4'b0000,4'd4,32'h0,        0, 1,32'h89ABCDEF, 1,32'h01234567);

    // Reset state, then the start-up clear must take exactly N cycles.
    repeat (3) step();
    check("rst_ready", ready, 0);
    check("rst_validA", validOutA, 0);
    check("rst_validB", validOutB, 0);
    check("rst_dataA", dataOutA, 0);
    check("rst_dataB", dataOutB, 0);
    check("rst_collision", collision, 0);
    reset = 0;
    wait_ready(N + 10, n);
    check("startup_clear_cycles", n, N);
    read_all_zero("startup_zero");

    for (int i = 0; i < NV; i++) begin
      idle();
      enA = vecs[i].enA; weA = vecs[i].weA; beA = vecs[i].beA; adA = vecs[i].adA; dA = vecs[i].dA;
      enB = vecs[i].enB; weB = vecs[i].weB; beB = vecs[i].beB; adB = vecs[i].adB; dB = vecs[i].dB;
      step();
      check($sformatf("vec%0d_collision", i), collision, vecs[i].expC);
      idle();
      repeat (L - 1) step();
      check($sformatf("vec%0d_validA", i), validOutA, vecs[i].expVA);
      check($sformatf("vec%0d_validB", i), validOutB, vecs[i].expVB);
      if (vecs[i].expVA) check($sformatf("vec%0d_dataA", i), dataOutA, vecs[i].expDA);
      if (vecs[i].expVB) check($sformatf("vec%0d_dataB", i), dataOutB, vecs[i].expDB);
    end

    // A read accepted in the clearRequest cycle still delivers its data.
    wr(4'd2, 32'h01020304, 4'b1111);
    idle(); enA = 1; adA = 4'd2; clr = 1;
    step(); idle();
    repeat (L - 1) step();
    check("clr_outstanding_valid", validOutA, 1);
    check("clr_outstanding_data", dataOutA, 32'h01020304);
    check("clr_ready_low", ready, 0);
    wait_ready(N + 10, n);
    check("clr_outstanding_ready", ready, 1);

    // Randomized traffic, including clears, against the reference model.
    clearLeft = 0;
    for (int cyc = 0; cyc < NRAND; cyc++) begin
      idle();
      if (cyc == 0) begin
        clr = 1;
      end else begin
        enA = 1'($urandom_range(0, 1)); weA = 1'($urandom_range(0, 1));
        beA = 4'($urandom_range(0, 15)); adA = 4'($urandom_range(0, 15)); dA = $urandom();
        enB = 1'($urandom_range(0, 1)); weB = 1'($urandom_range(0, 1));
        beB = 4'($urandom_range(0, 15)); adB = 4'($urandom_range(0, 15)); dB = $urandom();
        if ($urandom_range(0, 3) == 0) adB = adA;
        clr = ($urandom_range(0, 199) == 0);
      end
      acc  = (clearLeft == 0);
      wa   = acc && enA && weA && (adA < N);
      wb   = acc && enB && weB && (adB < N);
      expC = wa && wb && (adA == adB);
      ea.v = acc && enA && !weA;
      eb.v = acc && enB && !weB;
      ea.d = (ea.v && adA < N) ? ((RAW != 0) ? mnew(int'(adA), wa, wb) : m[adA]) : 32'h0;
      eb.d = (eb.v && adB < N) ? ((RAW != 0) ? mnew(int'(adB), wa, wb) : m[adB]) : 32'h0;
      na = wa ? mnew(int'(adA), wa, wb) : 32'h0;
      nb = wb ? mnew(int'(adB), wa, wb) : 32'h0;
      if (wa) m[adA] = na;
      if (wb) m[adB] = nb;
      if (clr) begin
        clearLeft = N;
        for (int k = 0; k < N; k++) m[k] = 32'h0;
      end else if (clearLeft > 0) begin
        clearLeft--;
      end
      qA.push_back(ea);
      qB.push_back(eb);
      step();
      check("rnd_ready", ready, (clearLeft == 0));
      check("rnd_collision", collision, expC);
      if (qA.size() >= L) begin
        e = qA.pop_front();
        check("rnd_validA", validOutA, e.v);
        if (e.v) check("rnd_dataA", dataOutA, e.d);
        e = qB.pop_front();
        check("rnd_validB", validOutB, e.v);
        if (e.v) check("rnd_dataB", dataOutB, e.d);
      end
    end
    idle();
    repeat (L) step();

    // clearRequest with traffic: requests ignored, N cycles, memory zero afterwards.
    wr(4'd1, 32'h5A5A5A5A, 4'b1111);
    idle(); clr = 1;
    step(); idle();
    check("clear_ready_low", ready, 0);
    n = 0;
    while (!ready && n < N + 10) begin
      enA = 1; weA = 1; beA = 4'hF; adA = 4'd1; dA = 32'hFFFFFFFF;
      enB = 1; weB = 0; adB = 4'd1;
      step(); n++;
      check("clear_ignored_validB", validOutB, 0);
    end
    idle();
    check("clear_cycles", n, N);
    read_all_zero("clear_zero");

`ifdef DUAL_PORT_BRAM_PARITY_EN
    wr(4'd9, 32'h0F0F0F0F, 4'b1111);
    dut.mem[9][0] = ~dut.mem[9][0];
    idle(); enA = 1; adA = 4'd9;
    step(); idle();
    repeat (L - 1) step();
    check("par_validA", validOutA, 1);
    check("par_errorA", parityErrorA, 1);
    idle(); enA = 1; adA = 4'd4;
    step(); idle();
    repeat (L - 1) step();
    check("par_clean_errorA", parityErrorA, 0);
`endif

    // Asynchronous reset clears outputs without waiting for a clock edge.
    wr(4'd5, 32'hCAFEF00D, 4'b1111);
    rdA(4'd5, 32'hCAFEF00D, "pre_async_read");
    reset = 1;
    #1;
    check("async_rst_ready", ready, 0);
    check("async_rst_validA", validOutA, 0);
    check("async_rst_dataA", dataOutA, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_port_bram.md
DUAL_PORT_BRAM -- requirements
Module: dual_port_bram

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32, word width in bits; a multiple of 8, minimum 8.
REQ-002 SHALL have parameter NR_OF_ENTRIES, default 512, words per memory; minimum 2.
REQ-003 SHALL have parameter READ_AFTER_WRITE, default 0; 0 = same-cycle read of a written address returns old data, 1 = returns new data.
REQ-004 SHALL have parameter OUTPUT_REG, default 0; 1 adds one output pipeline stage on both ports.
REQ-005 SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-006 clock  input  1  sole clock; all state on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 clearRequest  input  1  pulse; restarts the memory-clear sequence.
REQ-009 ready  output  1  high when ports are accepted (state READY).
REQ-010 enableA, enableB  input  1  port access request.
REQ-011 writeEnableA, writeEnableB  input  1  write when enabled, read otherwise.
REQ-012 byteEnableA, byteEnableB  input  BITWIDTH/8  per-byte write mask.
REQ-013 addressA, addressB  input  $clog2(NR_OF_ENTRIES)  word address.
REQ-014 dataInA, dataInB  input  BITWIDTH  write data.
REQ-015 dataOutA, dataOutB  output  BITWIDTH  read data.
REQ-016 validOutA, validOutB  output  1  dataOut qualifier, one cycle per accepted read.
REQ-017 collision  output  1  one-cycle pulse: both ports wrote the same address.

Function
REQ-018 State machine: CLEAR (writes zero to address counter, counter +1 per cycle, ready=0) -> READY after address NR_OF_ENTRIES-1 is written; READY -> CLEAR on clearRequest, counter reset to 0.
REQ-019 Port requests while ready=0 SHALL be ignored: no write, no validOut.
REQ-020 Accepted read latency SHALL be 1 + OUTPUT_REG cycles; validOut asserted on the same cycle as the data.
REQ-021 Writes SHALL update only bytes whose byteEnable bit is 1; byteEnable all-zero is a no-op write that returns no read data.
REQ-022 Same-address write/write: port A bytes win where byteEnableA=1; port B bytes land where byteEnableA=0 and byteEnableB=1; collision pulses the next cycle.
REQ-023 Same-address read/write across ports or on a single port SHALL follow READ_AFTER_WRITE; new data = merge of old word and enabled written bytes (including REQ-022 result).
REQ-024 Address >= NR_OF_ENTRIES (non-power-of-2 depth) SHALL be ignored for writes and read as zero.
REQ-025 clearRequest during CLEAR SHALL restart the counter at 0.
REQ-026 Outstanding reads in the pipeline at clearRequest SHALL still complete with their captured data.

Reset
REQ-027 reset SHALL force state CLEAR, counter 0, ready 0, dataOutA/B 0, validOutA/B 0, collision 0, pipeline registers 0; memory contents are cleared by the ensuing CLEAR sequence, not by reset.

Configuration
REQ-028 Macro DUAL_PORT_BRAM_PARITY_EN, when defined, SHALL store one even-parity bit per byte, add outputs parityErrorA/parityErrorB (1 bit each, aligned with validOut, high if any read byte fails parity), and the CLEAR sequence SHALL write correct parity.
REQ-029 Without DUAL_PORT_BRAM_PARITY_EN, no parity storage and no parityError ports SHALL exist.

Structure
REQ-030 A shared package dual_port_bram_pkg SHALL hold the state typedef (CLEAR, READY) and the byte-merge/parity helper functions.
REQ-031 One sub-module dual_port_bram_outreg (per-port optional output/valid register) SHALL be instantiated twice.

Verification
REQ-032 Reset released, idle -> ready rises exactly NR_OF_ENTRIES cycles later; every address then reads 0.
REQ-033 A writes 0xDEADBEEF @5, byteEnableA=4'b0011; A reads @5 -> 0x0000BEEF after 1+OUTPUT_REG cycles.
REQ-034 Same cycle A writes 0x11111111 be=0011, B writes 0x22222222 be=1111 @7 -> collision pulse next cycle; read @7 -> 0x22221111.
REQ-035 A writes 0xAAAAAAAA @3 while B reads @3 (old 0) -> dataOutB 0 with READ_AFTER_WRITE=0, 0xAAAAAAAA with 1.
REQ-036 clearRequest mid-traffic -> ready low, requests ignored, after NR_OF_ENTRIES cycles ready high and all words 0.
REQ-037 With DUAL_PORT_BRAM_PARITY_EN, force flip of a stored bit @9 then read @9 -> parityErrorA=1 with validOutA=1.
